// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command framer: opcodes, wire-protocol
// command bytes, FSM state encoding and the error-pulse bundle.
package uart_cmd_decoder_pkg;

   // Opcodes presented to the core on cmd_op
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_START = 2'b10;

   // CMD byte values as they appear on the wire
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_START = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_CMD  = 3'd1,
      ST_GET_ADDR = 3'd2,
      ST_GET_DATA = 3'd3,
      ST_GET_CHK  = 3'd4,
      ST_ISSUE    = 3'd5
   } state_t;

   typedef struct packed {
      logic chk;
      logic op;
      logic ovr;
      logic to;
   } err_t;

   // True while a frame is partially received (inter-byte timer runs)
   function automatic logic is_get_state(input state_t s);
      return (s == ST_GET_CMD) || (s == ST_GET_ADDR) ||
             (s == ST_GET_DATA) || (s == ST_GET_CHK);
   endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter: cleared by clr_i, counts while en_i, and
// raises expire_o combinationally in the cycle the limit is reached.
module uart_frame_timeout #(
   parameter int TIMEOUT_CYC = 20000,
   parameter int TO_W        = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   // Next count: clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // A clear (incoming byte) in the limit cycle suppresses expiry
   assign expire_o = en_i & ~clr_i & (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames received UART bytes into SYNC/CMD/ADDR/DATA/CHK packets, validates
// them and issues WRITE/START commands over a valid/ready port.
module uart_cmd_decoder #(
   parameter int                DBITS       = 8,
   parameter logic [DBITS-1:0]  SYNC_BYTE   = 'hA5,
   parameter int                TIMEOUT_CYC = 20000,
   parameter int                TO_W        = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] rx_data,
   input  logic             rx_done_tick,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [1:0]       cmd_op,
   output logic [DBITS-1:0] cmd_addr,
   output logic [DBITS-1:0] cmd_data,
   output logic             err_chk,
   output logic             err_op,
   output logic             err_ovr,
   output logic             err_to
);

   import uart_cmd_decoder_pkg::*;

   state_t           state_q, state_d;
   logic [DBITS-1:0] cmd_q, addr_q, data_q;
   logic [1:0]       op_q, op_d;
   err_t             err_q, err_d;
   logic             lat_cmd, lat_addr, lat_data;
   logic             to_en, to_clr, to_expire;

   // Timer runs only mid-frame; any byte restarts the gap measurement
   assign to_en  = is_get_state(state_q);
   assign to_clr = rx_done_tick | ~to_en;

   uart_frame_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_timeout (
      .clk      (clk),
      .rst      (reset),
      .clr_i    (to_clr),
      .en_i     (to_en),
      .expire_o (to_expire)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state, field latch enables, opcode select and error events
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      err_d    = '0;
      lat_cmd  = 1'b0;
      lat_addr = 1'b0;
      lat_data = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_done_tick && rx_data == SYNC_BYTE)
               state_d = ST_GET_CMD;
         end
         ST_GET_CMD: begin
            if (rx_done_tick) begin
               lat_cmd = 1'b1;
               state_d = ST_GET_ADDR;
            end else if (to_expire) begin
               err_d.to = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_GET_ADDR: begin
            if (rx_done_tick) begin
               lat_addr = 1'b1;
               state_d  = ST_GET_DATA;
            end else if (to_expire) begin
               err_d.to = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_GET_DATA: begin
            if (rx_done_tick) begin
               lat_data = 1'b1;
               state_d  = ST_GET_CHK;
            end else if (to_expire) begin
               err_d.to = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_GET_CHK: begin
            if (rx_done_tick) begin
               if (rx_data != (cmd_q ^ addr_q ^ data_q)) begin
                  err_d.chk = 1'b1;
                  state_d   = ST_IDLE;
               end else if (cmd_q == DBITS'(CMD_WRITE)) begin
                  op_d    = OP_WRITE;
                  state_d = ST_ISSUE;
               end else if (cmd_q == DBITS'(CMD_START)) begin
                  op_d    = OP_START;
                  state_d = ST_ISSUE;
               end else begin
                  err_d.op = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else if (to_expire) begin
               err_d.to = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // A byte arriving now is lost, even if the command is taken this cycle
            if (rx_done_tick)
               err_d.ovr = 1'b1;
            if (cmd_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame field, opcode and error-pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         op_q   <= '0;
         err_q  <= '0;
      end else begin
         if (lat_cmd)  cmd_q  <= rx_data;
         if (lat_addr) addr_q <= rx_data;
         if (lat_data) data_q <= rx_data;
         op_q  <= op_d;
         err_q <= err_d;
      end
   end

   // Outputs come straight from registers; valid is decoded from state
   always_comb begin
      cmd_valid = (state_q == ST_ISSUE);
      cmd_op    = op_q;
      cmd_addr  = addr_q;
      cmd_data  = data_q;
      err_chk   = err_q.chk;
      err_op    = err_q.op;
      err_ovr   = err_q.ovr;
      err_to    = err_q.to;
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected commands
// and error kinds; a negedge monitor pops and compares DUT outputs.
module tb_uart_cmd_decoder;

   localparam int TC = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done_tick = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [7:0] cmd_addr, cmd_data;
   logic       err_chk, err_op, err_ovr, err_to;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   cmd_t exp_cmd[$];
   int   exp_err[$];   // 1=chk 2=op 3=ovr 4=to
   int   checks = 0;
   int   failures = 0;
   int   nerr, code;

   always #5 clk = ~clk;

   uart_cmd_decoder #(
      .DBITS       (8),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TC),
      .TO_W        (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .err_chk      (err_chk),
      .err_op       (err_op),
      .err_ovr      (err_ovr),
      .err_to       (err_to)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every presented command and every error pulse
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid) begin
            if (exp_cmd.size() == 0) begin
               check("unexpected_cmd", 32'(cmd_valid), 32'd0);
            end else begin
               check("cmd_op",   32'(cmd_op),   32'(exp_cmd[0].op));
               check("cmd_addr", 32'(cmd_addr), 32'(exp_cmd[0].addr));
               check("cmd_data", 32'(cmd_data), 32'(exp_cmd[0].data));
               if (cmd_ready) void'(exp_cmd.pop_front());
            end
         end
         nerr = $countones({err_chk, err_op, err_ovr, err_to});
         if (nerr != 0) begin
            check("err_onehot", 32'(nerr), 32'd1);
            code = err_chk ? 1 : err_op ? 2 : err_ovr ? 3 : 4;
            if (exp_err.size() == 0)
               check("unexpected_err", 32'(code), 32'd0);
            else
               check("err_kind", 32'(code), 32'(exp_err.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
      send(8'hA5); send(c); send(a); send(d); send(k);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
      check({tag, "_op"},    32'(cmd_op),    32'd0);
      check({tag, "_addr"},  32'(cmd_addr),  32'd0);
      check({tag, "_data"},  32'(cmd_data),  32'd0);
      check({tag, "_errs"},  32'({err_chk, err_op, err_ovr, err_to}), 32'd0);
   endtask

   initial begin
      idle(2);
      check_all_zero("reset");
      reset = 1'b0;
      idle(2);

      // 1: WRITE accepted immediately
      cmd_ready = 1'b1;
      exp_cmd.push_back({2'b01, 8'h10, 8'h3C});
      send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
      check("t1_latency", 32'(cmd_valid), 32'd1);
      idle(1);
      check("t1_valid_fall", 32'(cmd_valid), 32'd0);

      // 2: START held under backpressure
      cmd_ready = 1'b0;
      exp_cmd.push_back({2'b10, 8'h00, 8'h00});
      send_frame(8'h02, 8'h00, 8'h00, 8'h02);
      check("t2_latency", 32'(cmd_valid), 32'd1);
      idle(50);
      check("t2_held", 32'(cmd_valid), 32'd1);
      cmd_ready = 1'b1;
      idle(1);
      check("t2_valid_fall", 32'(cmd_valid), 32'd0);

      // 3: bad checksum, then a good frame
      exp_err.push_back(1);
      send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
      idle(3);
      check("t3_no_valid", 32'(cmd_valid), 32'd0);
      exp_cmd.push_back({2'b01, 8'h10, 8'h3C});
      send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
      idle(2);

      // 4: unknown opcode, then junk byte before a frame
      exp_err.push_back(2);
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);
      idle(3);
      check("t4_no_valid", 32'(cmd_valid), 32'd0);
      exp_cmd.push_back({2'b01, 8'h20, 8'h11});
      send(8'h55);
      send_frame(8'h01, 8'h20, 8'h11, 8'h30);
      idle(2);

      // 5: timeout after exactly TC idle cycles
      send(8'hA5); send(8'h01);
      idle(TC - 1);
      check("t5_no_early_to", 32'(err_to), 32'd0);
      exp_err.push_back(4);
      idle(1);
      check("t5_to", 32'(err_to), 32'd1);
      idle(1);
      check("t5_to_pulse", 32'(err_to), 32'd0);
      send(8'h10); send(8'h3C); send(8'h2D);   // leftover bytes must be ignored
      idle(3);
      check("t5_idle_after_to", 32'(cmd_valid), 32'd0);
      // gaps just below the limit, and a tick landing on the limit cycle
      exp_cmd.push_back({2'b01, 8'h10, 8'h3C});
      send(8'hA5); send(8'h01); send(8'h10);
      idle(TC - 2);
      send(8'h3C); send(8'h2D);
      idle(2);
      exp_cmd.push_back({2'b01, 8'h10, 8'h3C});
      send(8'hA5); send(8'h01);
      idle(TC - 1);
      send(8'h10); send(8'h3C); send(8'h2D);
      idle(2);

      // 6: overrun while pending, then overrun coinciding with acceptance
      cmd_ready = 1'b0;
      exp_cmd.push_back({2'b10, 8'h44, 8'h55});
      send_frame(8'h02, 8'h44, 8'h55, 8'h13);
      exp_err.push_back(3);
      idle(3);
      send(8'h77);
      idle(3);
      check("t6_still_pending", 32'(cmd_valid), 32'd1);
      exp_err.push_back(3);
      cmd_ready = 1'b1;
      send(8'hA5);                             // dropped: must not start a frame
      check("t6_accept_with_ovr", 32'(cmd_valid), 32'd0);
      send(8'h01); send(8'h10); send(8'h3C); send(8'h2D);
      idle(3);
      check("t6_sync_dropped", 32'(cmd_valid), 32'd0);

      // reset mid-frame
      send(8'hA5); send(8'h01);
      reset = 1'b1;
      #1;
      check_all_zero("rst_frame");
      idle(1);
      reset = 1'b0;
      idle(1);
      send(8'h10); send(8'h3C); send(8'h2D);
      idle(3);
      check("rst_frame_idle", 32'(cmd_valid), 32'd0);
      exp_cmd.push_back({2'b01, 8'h10, 8'h3C});
      send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
      idle(2);

      // reset while a command is pending
      cmd_ready = 1'b0;
      exp_cmd.push_back({2'b01, 8'h66, 8'h77});
      send_frame(8'h01, 8'h66, 8'h77, 8'h10);
      idle(2);
      reset = 1'b1;
      #1;
      check("rst_issue_valid", 32'(cmd_valid), 32'd0);
      exp_cmd.delete();
      idle(1);
      reset = 1'b0;
      idle(2);
      check("rst_issue_after", 32'(cmd_valid), 32'd0);

      cmd_ready = 1'b1;
      idle(5);
      check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
      check("err_queue_empty", 32'(exp_err.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
